// File: rtl/stabilizer_row_collector_pkg.sv
// Shared stabilizer definitions: collector FSM state encoding and 2-bit Pauli literal encoding.
// No logic, so no latency.
// No flow control lives here.
package stabilizer_row_collector_pkg;

    // Collector FSM state encoding
    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_COLLECT_ENC = 2'd1;
    localparam logic [1:0] ST_FULL_ENC    = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE_ENC,
        S_COLLECT = ST_COLLECT_ENC,
        S_FULL    = ST_FULL_ENC
    } collector_state_t;

    // Pauli literal encoding, two bits per qubit
    localparam logic [1:0] LIT_I = 2'd0;
    localparam logic [1:0] LIT_X = 2'd1;
    localparam logic [1:0] LIT_Z = 2'd2;
    localparam logic [1:0] LIT_Y = 2'd3;

endpackage

// File: rtl/stabilizer_row_collector.sv
// Assembles a bottom-first stabilizer row stream into a full literal/phase matrix frame.
// Latency: frame_valid rises one cycle after the last row of a frame is sampled.
// Backpressure: none on the source; rows arriving while a frame is held are dropped and flagged in overflow.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   valid_in        one row presented this cycle
//   literals_in     row literals, 2 bits per qubit
//   phase_in        row phase bits
//   clear           synchronous abort of the current frame (highest priority)
//   ack             consumer has taken the held frame
//   literal_mat     assembled literals [row][col]
//   phase_mat       assembled phases [row][pair]
//   frame_valid     a complete frame is held
//   ready           rows can be accepted
//   row_count       rows received in the current frame
//   overflow        sticky: a row arrived while a frame was held
module stabilizer_row_collector
    import stabilizer_row_collector_pkg::*;
#(
    parameter int num_qubit  = 4,
    parameter int max_vector = 2**num_qubit
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      valid_in,
    input  logic [num_qubit-1:0][1:0]                 literals_in,
    input  logic [max_vector-1:0]                     phase_in,
    input  logic                                      clear,
    input  logic                                      ack,
    output logic [num_qubit-1:0][num_qubit-1:0][1:0]  literal_mat,
    output logic [num_qubit-1:0][max_vector-1:0]      phase_mat,
    output logic                                      frame_valid,
    output logic                                      ready,
    output logic [31:0]                               row_count,
    output logic                                      overflow
);

    localparam int IDX_W = (num_qubit > 1) ? $clog2(num_qubit) : 1;

    collector_state_t                           r_state;
    logic [num_qubit-1:0][num_qubit-1:0][1:0]   r_lit;
    logic [num_qubit-1:0][max_vector-1:0]       r_phase;
    logic [31:0]                                r_row_count;
    logic                                       r_overflow;

    collector_state_t   w_state_nxt;
    logic [31:0]        w_count_nxt;
    logic               w_ovf_nxt;
    logic               w_accept;
    logic [31:0]        w_k;        // position of the accepted row within its frame
    logic [31:0]        w_wr_idx;   // matrix row it lands in (stream is bottom-first)

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_row_count;
        w_ovf_nxt   = r_overflow;
        w_accept    = 1'b0;
        w_k         = 32'd0;

        if (clear) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = 32'd0;
            w_ovf_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_in) begin
                        w_accept    = 1'b1;
                        w_count_nxt = 32'd1;
                        w_state_nxt = (num_qubit == 1) ? S_FULL : S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (valid_in) begin
                        w_accept    = 1'b1;
                        w_k         = r_row_count;
                        w_count_nxt = r_row_count + 32'd1;
                        if (r_row_count + 32'd1 == 32'(num_qubit)) begin
                            w_state_nxt = S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (ack && valid_in) begin
                        // Release the held frame and start the next one with this row
                        w_accept    = 1'b1;
                        w_count_nxt = 32'd1;
                        w_state_nxt = (num_qubit == 1) ? S_FULL : S_COLLECT;
                    end else if (ack) begin
                        w_count_nxt = 32'd0;
                        w_state_nxt = S_IDLE;
                    end else if (valid_in) begin
                        w_ovf_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = 32'd0;
                end
            endcase
        end
    end

    assign w_wr_idx = 32'(num_qubit - 1) - w_k;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lit       <= '0;
            r_phase     <= '0;
            r_row_count <= 32'd0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_row_count <= w_count_nxt;
            r_overflow  <= w_ovf_nxt;
            if (w_accept) begin
                r_lit[w_wr_idx[IDX_W-1:0]]   <= literals_in;
                r_phase[w_wr_idx[IDX_W-1:0]] <= phase_in;
            end
        end
    end

    assign literal_mat = r_lit;
    assign phase_mat   = r_phase;
    assign row_count   = r_row_count;
    assign overflow    = r_overflow;
    assign frame_valid = (r_state == S_FULL);
    assign ready       = (r_state != S_FULL);

endmodule

// File: tb/tb_stabilizer_row_collector.sv
// Self-checking bench for stabilizer_row_collector (num_qubit=4, max_vector=16).
// Latency: model is updated at each active edge and compared at the following falling edge.
// Backpressure: none; the bench drives rows freely, including while a frame is held.
module tb_stabilizer_row_collector;

    localparam int NQ = 4;
    localparam int MV = 16;

    logic                        clk;
    logic                        rst;
    logic                        valid_in;
    logic [NQ-1:0][1:0]          literals_in;
    logic [MV-1:0]               phase_in;
    logic                        clear;
    logic                        ack;
    logic [NQ-1:0][NQ-1:0][1:0]  literal_mat;
    logic [NQ-1:0][MV-1:0]       phase_mat;
    logic                        frame_valid;
    logic                        ready;
    logic [31:0]                 row_count;
    logic                        overflow;

    stabilizer_row_collector #(.num_qubit(NQ), .max_vector(MV)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .literals_in (literals_in),
        .phase_in    (phase_in),
        .clear       (clear),
        .ack         (ack),
        .literal_mat (literal_mat),
        .phase_mat   (phase_mat),
        .frame_valid (frame_valid),
        .ready       (ready),
        .row_count   (row_count),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: a frame is a count of rows seen plus a "held" flag
    logic [NQ-1:0][NQ-1:0][1:0]  m_lit;
    logic [NQ-1:0][MV-1:0]       m_ph;
    int                          m_cnt;
    bit                          m_held;
    bit                          m_ovf;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_lit  = '0;
        m_ph   = '0;
        m_cnt  = 0;
        m_held = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_store(input logic [7:0] l, input logic [15:0] p);
        m_lit[NQ-1-m_cnt] = l;
        m_ph[NQ-1-m_cnt]  = p;
        m_cnt++;
        if (m_cnt == NQ) m_held = 1'b1;
    endtask

    task automatic model_step(input logic v, input logic c, input logic a,
                              input logic [7:0] l, input logic [15:0] p);
        if (c) begin
            m_cnt = 0; m_held = 1'b0; m_ovf = 1'b0;
        end else if (m_held) begin
            if (a) begin
                m_held = 1'b0;
                m_cnt  = 0;
                if (v) model_store(l, p);
            end else if (v) begin
                m_ovf = 1'b1;
            end
        end else if (v) begin
            model_store(l, p);
        end
    endtask

    // One clock cycle of stimulus; returns 1 time unit after the active edge
    task automatic cyc(input logic v, input logic c, input logic a,
                       input logic [7:0] l, input logic [15:0] p);
        valid_in    = v;
        clear       = c;
        ack         = a;
        literals_in = l;
        phase_in    = p;
        @(posedge clk);
        model_step(v, c, a, l, p);
        #1;
        valid_in = 1'b0; clear = 1'b0; ack = 1'b0;
    endtask

    function automatic logic [7:0] rep(input logic [1:0] v);
        return {v, v, v, v};
    endfunction

    // Continuous comparison against the model on every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("frame_valid", 64'(frame_valid), 64'(m_held));
            check("ready",       64'(ready),       64'(!m_held));
            check("row_count",   64'(row_count),   64'(m_cnt));
            check("overflow",    64'(overflow),    64'(m_ovf));
            check("literal_mat", 64'(literal_mat), 64'(m_lit));
            check("phase_mat",   64'(phase_mat),   64'(m_ph));
        end
    end

    logic [7:0]  rl;
    logic [15:0] rp;

    initial begin
        rst = 1'b1; valid_in = 1'b0; clear = 1'b0; ack = 1'b0;
        literals_in = '0; phase_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_ready",  64'(ready), 64'd1);
        check("rst_fv",     64'(frame_valid), 64'd0);
        check("rst_count",  64'(row_count), 64'd0);
        check("rst_ovf",    64'(overflow), 64'd0);
        check("rst_lit",    64'(literal_mat), 64'd0);
        check("rst_phase",  64'(phase_mat), 64'd0);
        chk_en = 1'b1;

        // Unbroken frame: literals 1,2,3,0 and phase[0] = row parity
        for (int k = 0; k < NQ; k++) cyc(1, 0, 0, rep(2'((k + 1) % 4)), 16'(k & 1));
        check("seq_fv",     64'(frame_valid), 64'd1);
        check("seq_lit3",   64'(literal_mat[3]), 64'h55);
        check("seq_lit0",   64'(literal_mat[0]), 64'h00);
        check("seq_lit",    64'(literal_mat), 64'h55AAFF00);
        check("seq_ph",     64'(phase_mat), 64'h0000_0001_0000_0001);
        check("seq_count",  64'(row_count), 64'd4);
        cyc(0, 0, 1, 8'h00, 16'h0);
        check("ack_idle",   64'(ready), 64'd1);
        check("ack_count",  64'(row_count), 64'd0);
        check("ack_keep",   64'(literal_mat), 64'h55AAFF00);

        // Same frame with two idle cycles between rows 1 and 2
        cyc(1, 0, 0, rep(2'd1), 16'd0);
        cyc(1, 0, 0, rep(2'd2), 16'd1);
        cyc(0, 0, 0, 8'hC3, 16'h5A5A);
        cyc(0, 0, 0, 8'h3C, 16'hA5A5);
        cyc(1, 0, 0, rep(2'd3), 16'd0);
        check("gap_fv_early", 64'(frame_valid), 64'd0);
        check("gap_count3",   64'(row_count), 64'd3);
        cyc(1, 0, 0, rep(2'd0), 16'd1);
        check("gap_fv",     64'(frame_valid), 64'd1);
        check("gap_lit",    64'(literal_mat), 64'h55AAFF00);

        // Extra row while FULL without ack
        cyc(1, 0, 0, 8'hE4, 16'hFFFF);
        check("ovf_set",    64'(overflow), 64'd1);
        check("ovf_lit",    64'(literal_mat), 64'h55AAFF00);
        check("ovf_ph",     64'(phase_mat), 64'h0000_0001_0000_0001);
        cyc(0, 0, 1, 8'h00, 16'h0);
        check("ovf_idle",   64'(ready), 64'd1);
        check("ovf_sticky", 64'(overflow), 64'd1);
        cyc(0, 1, 0, 8'h00, 16'h0);
        check("clr_ovf",    64'(overflow), 64'd0);

        // ack and valid_in together while FULL
        for (int k = 0; k < NQ; k++) cyc(1, 0, 0, 8'($urandom), 16'($urandom));
        cyc(1, 0, 1, 8'h9C, 16'h1234);
        check("ackv_count", 64'(row_count), 64'd1);
        check("ackv_fv",    64'(frame_valid), 64'd0);
        check("ackv_row3",  64'(literal_mat[3]), 64'h9C);
        check("ackv_ph3",   64'(phase_mat[3]), 64'h1234);
        check("ackv_ovf",   64'(overflow), 64'd0);
        for (int k = 1; k < NQ; k++) cyc(1, 0, 0, 8'($urandom), 16'($urandom));
        cyc(0, 0, 1, 8'h00, 16'h0);

        // clear after two rows, then a fresh frame
        cyc(1, 0, 0, rep(2'd3), 16'hFFFF);
        cyc(1, 0, 0, rep(2'd3), 16'hFFFF);
        cyc(1, 1, 0, rep(2'd2), 16'h0F0F);
        check("clr_count",  64'(row_count), 64'd0);
        check("clr_fv",     64'(frame_valid), 64'd0);
        for (int k = 0; k < NQ; k++) begin
            cyc(1, 0, 0, rep(2'(k)), 16'(k));
            check("clr_cnt_step", 64'(row_count), 64'(k + 1));
        end
        check("clr_lit",    64'(literal_mat), 64'h0055AAFF);
        check("clr_ph",     64'(phase_mat), 64'h0000_0001_0002_0003);
        cyc(0, 0, 1, 8'h00, 16'h0);

        // Asynchronous reset mid-frame
        for (int k = 0; k < 3; k++) cyc(1, 0, 0, 8'($urandom), 16'($urandom));
        #2 rst = 1'b1;
        #1;
        check("arst_fv",    64'(frame_valid), 64'd0);
        check("arst_ready", 64'(ready), 64'd1);
        check("arst_count", 64'(row_count), 64'd0);
        check("arst_ovf",   64'(overflow), 64'd0);
        check("arst_lit",   64'(literal_mat), 64'd0);
        check("arst_ph",    64'(phase_mat), 64'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, 0, 8'h00, 16'h0);
            check("arst_nopulse", 64'(frame_valid), 64'd0);
        end

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            rl = 8'($urandom);
            rp = 16'($urandom);
            cyc(logic'($urandom_range(99) < 60), logic'($urandom_range(99) < 3),
                logic'($urandom_range(99) < 30), rl, rp);
        end

        chk_en = 1'b0;
        @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/stabilizer_row_collector.md
STABILIZER_ROW_COLLECTOR -- requirements
Module: stabilizer_row_collector

Interface
REQ-001 The block SHALL have parameter num_qubit, default 4: rows per frame and literals per row.
REQ-002 The block SHALL have parameter max_vector, default 2**num_qubit: phase bits per row.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port valid_in, input, 1 bit: one row presented this cycle; no backpressure on the source.
REQ-006 The block SHALL have port literals_in, input, [1:0] x num_qubit: incoming row literals.
REQ-007 The block SHALL have port phase_in, input, 1 bit x max_vector: incoming row phases.
REQ-008 The block SHALL have port clear, input, 1 bit: synchronous abort; discards any partial frame.
REQ-009 The block SHALL have port ack, input, 1 bit: consumer has taken the held frame.
REQ-010 The block SHALL have port literal_mat, output, [1:0] x num_qubit x num_qubit: assembled literals [row][col].
REQ-011 The block SHALL have port phase_mat, output, 1 bit x num_qubit x max_vector: assembled phases [row][pair].
REQ-012 The block SHALL have port frame_valid, output, 1 bit: a complete frame is held on literal_mat/phase_mat.
REQ-013 The block SHALL have port ready, output, 1 bit: the block can accept rows (state not FULL).
REQ-014 The block SHALL have port row_count, output, 32 bits: rows received in the current frame.
REQ-015 The block SHALL have port overflow, output, 1 bit: sticky; a row arrived while FULL.

Function
REQ-016 The block SHALL be the receiving end of the stabilizer register-array row stream, which emits rows bottom-first, one per valid cycle.
REQ-017 The k-th accepted row of a frame (k = 0..num_qubit-1) SHALL be written to matrix row num_qubit-1-k, literals and phases together.
REQ-018 The FSM SHALL have three states: IDLE, COLLECT and FULL.
REQ-019 IDLE with valid_in: store the row, row_count=1, go to COLLECT; if num_qubit==1, go directly to FULL.
REQ-020 COLLECT with valid_in: store the row and increment row_count; on the row that makes row_count==num_qubit, go to FULL.
REQ-021 COLLECT without valid_in (gap cycles) SHALL hold all state; gaps are legal.
REQ-022 In FULL, frame_valid=1 and ready=0; the matrix SHALL be stable until ack.
REQ-023 FULL with ack: go to IDLE and set row_count=0 in the next cycle; the matrix contents are retained and not cleared.
REQ-024 FULL with valid_in and no ack: drop the row and set overflow=1; the matrix is unchanged.
REQ-025 FULL with ack and valid_in in the same cycle: accept the row as row 0 of a new frame (row_count=1, COLLECT); no overflow.
REQ-026 clear SHALL have priority over all other inputs: go to IDLE, row_count=0, frame_valid=0, overflow=0; a valid_in in the same cycle is dropped.
REQ-027 frame_valid SHALL assert in the cycle after the last row is sampled (1-cycle latency).
REQ-028 ack outside FULL SHALL be ignored.
REQ-029 row_count SHALL never exceed num_qubit.
REQ-030 Outputs SHALL be registered, except ready and frame_valid, which are decoded from the state.

Reset
REQ-031 rst SHALL force: state IDLE, literal_mat all 2'd0, phase_mat all 0, row_count 0, overflow 0, frame_valid 0, ready 1.
REQ-032 rst asserted mid-frame SHALL discard the partial frame with no output pulse after release.

Structure
REQ-033 The state encoding localparams and the literal encoding (2-bit I/X/Z/Y) SHALL reside in the shared stabilizer package.
REQ-034 The block SHALL have a single module with no sub-modules; the row write-index decode SHALL be inline.

Verification
REQ-035 Test num_qubit=4 with 4 consecutive rows, literals 0x1,0x2,0x3,0x0 per row (all columns) and phase[0]=row parity: the next cycle shows frame_valid=1, literal_mat[3]=all 1, literal_mat[0]=all 0, and row_count=4.
REQ-036 Test 4 rows with 2 idle cycles between rows 1 and 2: the same matrix as an unbroken stream results, with frame_valid exactly 1 cycle after the 4th row.
REQ-037 Test FULL plus an extra valid_in without ack: overflow=1, the matrix is unchanged, and a following ack returns the block to IDLE with overflow still 1.
REQ-038 Test ack and valid_in in the same cycle while FULL: state COLLECT, row_count=1, the new row is in matrix row 3, and overflow=0.
REQ-039 Test clear after 2 rows, then 4 new rows: the frame holds only the new rows, and row_count goes 0 then 1..4.
REQ-040 Test rst asserted asynchronously after 3 rows: all outputs at reset values immediately, and frame_valid=0 for 10 idle cycles after release.
